mlp_layer_engine: RTL

//  Parametrised fully-connected layer engine: y = act(W*x) in signed Q(DATA_W-FRAC_W).FRAC_W fixed point.

---
 rtl/mlp_layer_engine.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mlp_layer_engine.sv
// Fully-connected layer engine: y = act(W*x) in signed fixed point, LANES neurons per
// pass, sequencing its own SRAM reads and streaming results over valid/ready.
module mlp_lane #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc_en,
    input  logic              acc_load,
    input  logic              quant_en,
    input  logic              relu,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    output logic [DATA_W-1:0] res
);
    localparam logic signed [ACC_W:0] HALF =
        {{(ACC_W+1-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W:0]      rnd;
    logic signed [ACC_W:0]      shifted;
    logic        [DATA_W-1:0]   q;

    assign prod     = $signed(x) * $signed(w);
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    // One guard bit so the rounding offset can never wrap the accumulator.
    assign rnd      = {acc[ACC_W-1], acc} + HALF;
    assign shifted  = rnd >>> FRAC_W;

    always_comb begin
        q = shifted[DATA_W-1:0];
        if (shifted > MAXV)
            q = {1'b0, {(DATA_W-1){1'b1}}};
        else if (shifted < MINV)
            q = {1'b1, {(DATA_W-1){1'b0}}};
        if (relu && q[DATA_W-1])
            q = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            res <= '0;
        end else begin
            if (acc_en)
                acc <= acc_load ? prod_ext : acc + prod_ext;
            if (quant_en)
                res <= q;
        end
    end
endmodule

module mlp_layer_engine #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int N_IN   = 16,
    parameter int N_OUT  = 16,
    parameter int LANES  = 4,
    parameter int ACC_W  = 40,
    localparam int NG    = N_OUT / LANES,
    localparam int GW    = (NG > 1) ? $clog2(NG) : 1,
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int XA_W  = $clog2(N_IN),
    localparam int WA_W  = $clog2(N_IN * NG),
    localparam int YI_W  = $clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    relu_en,
    output logic                    busy,
    output logic                    done,
    output logic                    x_rd_en,
    output logic [XA_W-1:0]         x_addr,
    input  logic [DATA_W-1:0]       x_data,
    output logic                    w_rd_en,
    output logic [WA_W-1:0]         w_addr,
    input  logic [LANES*DATA_W-1:0] w_data,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic [YI_W-1:0]         y_idx,
    output logic [DATA_W-1:0]       y_data
);
    if (N_OUT % LANES != 0) begin : g_bad_lanes
        $error("N_OUT must be a multiple of LANES");
    end
    if (ACC_W < 2*DATA_W + $clog2(N_IN)) begin : g_bad_acc
        $error("ACC_W too narrow for N_IN full-precision products");
    end

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_QUANT = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]                    state;
    logic [GW-1:0]                 g;
    logic [XA_W-1:0]               i;
    logic [LW-1:0]                 lane;
    logic                          relu_q;
    logic [1:0]                    vld_pipe;
    logic                          first_q;
    logic [LANES-1:0][DATA_W-1:0]  w_lanes;
    logic [LANES-1:0][DATA_W-1:0]  res;

    assign w_lanes = w_data;
    assign busy    = (state != S_IDLE) && (state != S_DONE);
    assign done    = (state == S_DONE);
    assign x_rd_en = (state == S_FETCH);
    assign w_rd_en = x_rd_en;
    assign x_addr  = i;
    assign w_addr  = WA_W'(g) * WA_W'(N_IN) + WA_W'(i);
    assign y_valid = (state == S_EMIT);
    assign y_idx   = YI_W'(g) * YI_W'(LANES) + YI_W'(lane);
    assign y_data  = y_valid ? res[lane] : '0;

    // SRAM data lags the read strobe by one cycle; vld_pipe[1] marks a product to accumulate.
    assign vld_pipe[0] = x_rd_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe[1] <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            first_q     <= vld_pipe[0] && (i == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            g      <= '0;
            i      <= '0;
            lane   <= '0;
            relu_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    relu_q <= relu_en;
                    g      <= '0;
                    i      <= '0;
                    state  <= S_FETCH;
                end
                S_FETCH: if (i == XA_W'(N_IN-1)) begin
                    i     <= '0;
                    state <= S_FLUSH;
                end else begin
                    i <= i + 1'b1;
                end
                S_FLUSH: state <= S_QUANT;
                S_QUANT: begin
                    lane  <= '0;
                    state <= S_EMIT;
                end
                S_EMIT: if (y_ready) begin
                    if (lane == LW'(LANES-1)) begin
                        lane <= '0;
                        if (g == GW'(NG-1)) begin
                            state <= S_DONE;
                        end else begin
                            g     <= g + 1'b1;
                            state <= S_FETCH;
                        end
                    end else begin
                        lane <= lane + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mlp_lane #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .acc_en   (vld_pipe[1]),
            .acc_load (first_q),
            .quant_en (state == S_QUANT),
            .relu     (relu_q),
            .x        (x_data),
            .w        (w_lanes[l]),
            .res      (res[l])
        );
    end
endmodule
